matrix_pingpong_buff: RTL
=========================

# matrix_pingpong_buff

Parametrised, double-buffered operand collector for the matrix multiplier. Accepts one A element and one B element per handshake and assembles two N×N matrices. Presents both matrices in parallel, column-indexed, to the downstream multiply array. Two banks let the next operand pair load while the multiplier holds the current one, so a continuous stream runs at one element pair per cycle.

## Interface

Parameters:
- DATA_W, 12: element width in bits.
- N, 4: matrix dimension. Must be ≥ 2. Each matrix holds N*N elements.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  a_in/b_in carry a valid element pair.
- ready_out  out  1  buffer can accept an element pair this cycle.
- a_in  in  DATA_W  A element.
- b_in  in  DATA_W  B element.
- ready_in  in  1  downstream consumes the presented matrix pair.
- valid_out  out  1  a_cols/b_cols hold a complete matrix pair.
- a_cols  out  [N-1:0][N-1:0][DATA_W-1:0]  A matrix, indexed [column][row].
- b_cols  out  [N-1:0][N-1:0][DATA_W-1:0]  B matrix, indexed [column][row].

## Operation

- Storage: two banks, each holding one A and one B matrix.
- State registers:
  - wr_bank: 1 bit, bank currently filling.
  - rd_bank: 1 bit, bank currently presented.
  - elem_cnt: 0..N*N-1, element index in wr_bank.
  - full_cnt: 0..2, number of complete banks.
- Accept: valid_in && ready_out at a rising edge.
  - Element k = elem_cnt is written to wr_bank at column k / N, row k % N (column-major fill).
  - elem_cnt increments.
- Bank complete: an accept with elem_cnt == N*N-1 wraps elem_cnt to 0, toggles wr_bank and increments full_cnt.
- Consume: valid_out && ready_in at a rising edge toggles rd_bank and decrements full_cnt.
  - Bank contents are not cleared on consume.
- Simultaneous bank complete and consume in one edge: full_cnt is unchanged, and both pointers toggle.
- ready_out = (full_cnt != 2).
- valid_out = (full_cnt != 0).
- Both flags decode registered state only. There is no combinational path from ready_in to ready_out, or from valid_in to valid_out.
- a_cols/b_cols always drive rd_bank contents. They are meaningful only while valid_out = 1.
- Beats with valid_in && !ready_out are not written. The producer holds the beat until it is accepted.
- Reset, asynchronous, including mid-fill or mid-hold:
  - Registers: elem_cnt = 0, full_cnt = 0, wr_bank = rd_bank = 0, all bank storage = 0.
  - Outputs: valid_out = 0, ready_out = 1, a_cols = b_cols = 0.
  - Any partial fill is discarded.
  - Inputs are ignored while rst is high.

## Timing

- Latency:
  - The last (N*N-th) element is accepted at edge t.
  - If the other bank was empty, valid_out = 1 and the full matrix is visible from edge t onward, available in the cycle after t.
- Throughput:
  - With ready_in held at 1, the buffer accepts one element pair every cycle and never deasserts ready_out.
  - valid_out is high for one cycle per completed matrix pair.
- Backpressure:
  - With both banks full, ready_out = 0.
  - A consume at edge t restores ready_out = 1 after edge t. There is a one-cycle refill bubble versus a combinational bypass, accepted by design.
- Hold:
  - While valid_out = 1 and ready_in = 0, a_cols/b_cols stay stable.
  - Filling of the other bank does not disturb them.

## Configuration

- MATRIX_BUFF_B_TRANSPOSE_EN:
  - Defined: B is filled row-major, so element k goes to b_cols[k % N][k / N]. B rows arrive on the columns port, so the multiplier receives B already transposed for row×column dot products. A is unaffected.
  - Undefined: B uses the same column-major fill as A.

## Test plan

Test plan values use N=4, DATA_W=12, with the macro undefined unless stated.

- Load / present: after reset, ready_in = 0; stream a_in = k+1, b_in = k+101 for k = 0..15 with valid_in held high.
  - valid_out rises the cycle after the 16th accept.
  - a_cols[0][0] = 1, a_cols[0][3] = 4, a_cols[3][3] = 16, b_cols[1][0] = 105.
  - ready_out stays 1.
- Both banks full: continue with values 17..32, ready_in = 0.
  - ready_out = 0 after the 32nd accept.
  - The 33rd beat (a = 33) is held and not written.
  - Outputs remain matrix 1 (a_cols[0][0] = 1).
- Consume: pulse ready_in for one cycle.
  - Next cycle: a_cols[0][0] = 17, valid_out = 1, ready_out = 1.
  - The held beat a = 33 is accepted on the following edge as element 0 of the freed bank.
- Streaming: ready_in = 1, valid_in = 1 for 64 cycles.
  - 4 matrices are produced; valid_out is a 1-cycle pulse every 16 cycles.
  - ready_out never drops; no element is lost or reordered.
- Reset mid-fill: assert rst after 7 accepts.
  - Immediately: valid_out = 0, ready_out = 1, a_cols = 0.
  - After release, 16 new elements starting at value 50 give a_cols[0][0] = 50.
- Transpose: with MATRIX_BUFF_B_TRANSPOSE_EN defined, load b_in = k+1.
  - b_cols[2][0] = 3, b_cols[0][1] = 5.
  - Without the macro, b_cols[0][2] = 3.

Source files
------------

// File: rtl/matrix_pingpong_buff.sv
// matrix_pingpong_buff
//   Double-buffered operand collector for the matrix multiplier. Element pairs
//   (A, B) arrive one per handshake and are assembled column-major into one of
//   two banks. The other bank is presented in parallel, column-indexed, to the
//   multiply array. A stream of one pair per cycle can run continuously while
//   the downstream holds the current pair.
//
//   Optional feature macro: MATRIX_BUFF_B_TRANSPOSE_EN
//     defined   : B is filled row-major (element k -> b_cols[k % N][k / N]).
//     undefined : B uses the same column-major fill as A.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset; clears pointers, counts, storage
//   valid_in   a_in/b_in carry an element pair
//   ready_out  buffer accepts an element pair this cycle (some bank not full)
//   a_in, b_in element pair
//   ready_in   downstream consumes the presented matrix pair
//   valid_out  a_cols/b_cols hold a complete matrix pair
//   a_cols     presented A matrix, [column][row]
//   b_cols     presented B matrix, [column][row]

module matrix_pingpong_buff #(
    parameter int DATA_W = 12,
    parameter int N      = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_in,
    output logic                             ready_out,
    input  logic [DATA_W-1:0]                a_in,
    input  logic [DATA_W-1:0]                b_in,
    input  logic                             ready_in,
    output logic                             valid_out,
    output logic [N-1:0][N-1:0][DATA_W-1:0]  a_cols,
    output logic [N-1:0][N-1:0][DATA_W-1:0]  b_cols
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef logic [N-1:0][N-1:0][DATA_W-1:0] mat_t;

    mat_t a_mem [2];
    mat_t b_mem [2];

    logic             wr_bank;
    logic             rd_bank;
    // The element index is held as its (column, row) pair: k = col_cnt*N + row_cnt.
    // This gives the write address directly without a divider.
    logic [IDX_W-1:0] col_cnt;
    logic [IDX_W-1:0] row_cnt;
    logic [1:0]       full_cnt;

    logic accept;
    logic consume;
    logic last_elem;
    logic bank_done;

    // Flags decode registered state only; no input-to-flag combinational path.
    assign ready_out = (full_cnt != 2'd2);
    assign valid_out = (full_cnt != 2'd0);

    assign accept    = valid_in && ready_out;
    assign consume   = valid_out && ready_in;
    assign last_elem = (col_cnt == IDX_W'(N - 1)) && (row_cnt == IDX_W'(N - 1));
    assign bank_done = accept && last_elem;

    assign a_cols = a_mem[rd_bank];
    assign b_cols = b_mem[rd_bank];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt  <= '0;
            row_cnt  <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full_cnt <= 2'd0;
        end else begin
            if (accept) begin
                if (row_cnt == IDX_W'(N - 1)) begin
                    row_cnt <= '0;
                    if (col_cnt == IDX_W'(N - 1)) begin
                        col_cnt <= '0;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end

            wr_bank <= wr_bank ^ bank_done;
            rd_bank <= rd_bank ^ consume;

            // Completion and consume on the same edge cancel in the count.
            unique case ({bank_done, consume})
                2'b10:   full_cnt <= full_cnt + 2'd1;
                2'b01:   full_cnt <= full_cnt - 2'd1;
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    // Storage is not cleared on consume; stale data is masked by valid_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_mem[0] <= '0;
            a_mem[1] <= '0;
            b_mem[0] <= '0;
            b_mem[1] <= '0;
        end else if (accept) begin
            a_mem[wr_bank][col_cnt][row_cnt] <= a_in;
`ifdef MATRIX_BUFF_B_TRANSPOSE_EN
            b_mem[wr_bank][row_cnt][col_cnt] <= b_in;
`else
            b_mem[wr_bank][col_cnt][row_cnt] <= b_in;
`endif
        end
    end

endmodule
